pipe_reg_file: RTL and testbench

Parametrised general-purpose register file for the pipelined successor of the single-cycle RISC-V core. It provides a configurable number of combinational read ports, one synchronous write port with same-cycle write-to-read bypass, and a hardwired-zero x0. A per-register busy scoreboard lets the decode stage reserve a destination at issue and detect RAW hazards until writeback clears the entry. It sits between decode (reads, reserve) and writeback (write).

---
 rtl/rv_pkg.sv | 15 +
 rtl/reg_file_rdport.sv | 33 +++
 rtl/pipe_reg_file.sv | 89 ++++++++
 tb/tb_pipe_reg_file.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// Types and constants shared by decode, writeback and the register file.
package rv_pkg;

    localparam int unsigned XLEN_DEFAULT  = 32;
    localparam int unsigned NREGS_DEFAULT = 32;
    localparam int unsigned REG_ZERO      = 0;

    typedef logic [$clog2(NREGS_DEFAULT)-1:0] reg_addr_t;

    // x0 and anything past the last implemented register are never stored or tracked.
    function automatic logic addr_valid(input logic [31:0] a, input int unsigned nregs);
        return (a != REG_ZERO) && (a < nregs);
    endfunction

endpackage

// File: rtl/reg_file_rdport.sv
// One combinational read port: address check, write bypass and busy lookup.
module reg_file_rdport
    import rv_pkg::*;
#(
    parameter int unsigned XLEN  = XLEN_DEFAULT,
    parameter int unsigned NREGS = NREGS_DEFAULT,
    parameter int unsigned AW    = $clog2(NREGS)
) (
    input  logic [AW-1:0]   ra_i,
    input  logic            we_i,
    input  logic [AW-1:0]   wa_i,
    input  logic [XLEN-1:0] wd_i,
    input  logic [XLEN-1:0] regs_i [NREGS],
    input  logic [NREGS-1:0] busy_i,
    output logic [XLEN-1:0] rd_o,
    output logic            rd_busy_o
);

    always_comb begin
        rd_o      = '0;
        rd_busy_o = 1'b0;
        if (addr_valid(32'(ra_i), NREGS)) begin
            // A writeback this cycle both supplies the data and retires the reservation.
            if (we_i && (wa_i == ra_i)) begin
                rd_o = wd_i;
            end else begin
                rd_o      = regs_i[ra_i];
                rd_busy_o = busy_i[ra_i];
            end
        end
    end

endmodule

// File: rtl/pipe_reg_file.sv
// Register file with hardwired x0, write-to-read bypass and a per-register busy scoreboard.
module pipe_reg_file
    import rv_pkg::*;
#(
    parameter int unsigned XLEN  = XLEN_DEFAULT,
    parameter int unsigned NREGS = NREGS_DEFAULT,
    parameter int unsigned NRD   = 2,
    parameter int unsigned AW    = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NRD*AW-1:0]   ra,
    output logic [NRD*XLEN-1:0] rd,
    output logic [NRD-1:0]      rd_busy,
    input  logic                we,
    input  logic [AW-1:0]       wa,
    input  logic [XLEN-1:0]     wd,
    input  logic                rsv_en,
    input  logic [AW-1:0]       rsv_a,
    input  logic                flush,
    output logic                pending
);

    logic [XLEN-1:0]  regs_q [1:NREGS-1];
    logic [XLEN-1:0]  regs_d [1:NREGS-1];
    logic [NREGS-1:1] busy_q;
    logic [NREGS-1:1] busy_d;

    logic [XLEN-1:0]  rf_view [NREGS];
    logic [NREGS-1:0] busy_view;

    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        for (int unsigned k = 1; k < NREGS; k++) begin
            if (we && (32'(wa) == k)) begin
                regs_d[k] = wd;
                busy_d[k] = 1'b0;
            end
            // Reserve wins over a same-edge writeback: the new producer is still in flight.
            if (rsv_en && !flush && (32'(rsv_a) == k)) begin
                busy_d[k] = 1'b1;
            end
        end
        if (flush) begin
            busy_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned k = 1; k < NREGS; k++) begin
                regs_q[k] <= '0;
            end
            busy_q <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
        end
    end

    always_comb begin
        rf_view[0] = '0;
        for (int unsigned k = 1; k < NREGS; k++) begin
            rf_view[k] = regs_q[k];
        end
        busy_view = {busy_q, 1'b0};
    end

    assign pending = |busy_q;

    for (genvar i = 0; i < NRD; i++) begin : g_rdport
        reg_file_rdport #(
            .XLEN  (XLEN),
            .NREGS (NREGS),
            .AW    (AW)
        ) u_rdport (
            .ra_i      (ra[i*AW +: AW]),
            .we_i      (we),
            .wa_i      (wa),
            .wd_i      (wd),
            .regs_i    (rf_view),
            .busy_i    (busy_view),
            .rd_o      (rd[i*XLEN +: XLEN]),
            .rd_busy_o (rd_busy[i])
        );
    end

endmodule

// File: tb/tb_pipe_reg_file.sv
// Directed bench: a default 32x32 two-port instance and a 24-register four-port instance.
module tb_pipe_reg_file;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Instance A: XLEN=32, NREGS=32, NRD=2
    logic [9:0]  ra_a = '0;
    logic [63:0] rd_a;
    logic [1:0]  rd_busy_a;
    logic        we_a = 1'b0, rsv_en_a = 1'b0, flush_a = 1'b0;
    logic [4:0]  wa_a = '0, rsv_a_a = '0;
    logic [31:0] wd_a = '0;
    logic        pending_a;

    // Instance B: XLEN=32, NREGS=24, NRD=4
    logic [19:0]  ra_b = '0;
    logic [127:0] rd_b;
    logic [3:0]   rd_busy_b;
    logic         we_b = 1'b0, rsv_en_b = 1'b0, flush_b = 1'b0;
    logic [4:0]   wa_b = '0, rsv_a_b = '0;
    logic [31:0]  wd_b = '0;
    logic         pending_b;

    int errors = 0;
    int checks = 0;

    pipe_reg_file u_dut_a (
        .clk     (clk),
        .rst     (rst),
        .ra      (ra_a),
        .rd      (rd_a),
        .rd_busy (rd_busy_a),
        .we      (we_a),
        .wa      (wa_a),
        .wd      (wd_a),
        .rsv_en  (rsv_en_a),
        .rsv_a   (rsv_a_a),
        .flush   (flush_a),
        .pending (pending_a)
    );

    pipe_reg_file #(
        .XLEN  (32),
        .NREGS (24),
        .NRD   (4)
    ) u_dut_b (
        .clk     (clk),
        .rst     (rst),
        .ra      (ra_b),
        .rd      (rd_b),
        .rd_busy (rd_busy_b),
        .we      (we_b),
        .wa      (wa_b),
        .wd      (wd_b),
        .rsv_en  (rsv_en_b),
        .rsv_a   (rsv_a_b),
        .flush   (flush_b),
        .pending (pending_b)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        we_a = 1'b0; rsv_en_a = 1'b0; flush_a = 1'b0;
        we_b = 1'b0; rsv_en_b = 1'b0; flush_b = 1'b0;
    endtask

    task automatic test_reset();
        #2 rst = 1'b0;
        #1;
        ra_a = {5'd5, 5'd1};
        #1;
        checks++;
        if (rd_a !== 64'h0) begin
            errors++; $display("FAIL reset_rd: got %h want 0", rd_a);
        end
        checks++;
        if (rd_busy_a !== 2'b00 || pending_a !== 1'b0) begin
            errors++; $display("FAIL reset_busy: got busy=%b pend=%b want 00/0", rd_busy_a, pending_a);
        end
        step();
        rst = 1'b1;
        step();
    endtask

    task automatic test_write_readback();
        we_a = 1'b1; wa_a = 5'd1; wd_a = 32'h0000_0001; step();
        wa_a = 5'd5; wd_a = 32'hFFFF_0000; step();
        wa_a = 5'd5; wd_a = 32'hADAD_0000; step();
        idle_inputs();
        ra_a = {5'd1, 5'd5};
        #1;
        checks++;
        if (rd_a[31:0] !== 32'hADAD_0000) begin
            errors++; $display("FAIL readback_x5: got %h want adad0000", rd_a[31:0]);
        end
        checks++;
        if (rd_a[63:32] !== 32'h0000_0001) begin
            errors++; $display("FAIL readback_x1: got %h want 00000001", rd_a[63:32]);
        end
        checks++;
        if (rd_busy_a !== 2'b00) begin
            errors++; $display("FAIL readback_busy: got %b want 00", rd_busy_a);
        end
    endtask

    task automatic test_x0_range();
        we_a = 1'b1; wa_a = 5'd0; wd_a = 32'hABCD_ABCD;
        rsv_en_a = 1'b1; rsv_a_a = 5'd0;
        we_b = 1'b1; wa_b = 5'd30; wd_b = 32'h1111_1111;
        rsv_en_b = 1'b1; rsv_a_b = 5'd30;
        step();
        idle_inputs();
        ra_a = {5'd5, 5'd0};
        ra_b = {5'd0, 5'd0, 5'd0, 5'd30};
        #1;
        checks++;
        if (rd_a[31:0] !== 32'h0 || rd_busy_a[0] !== 1'b0 || pending_a !== 1'b0) begin
            errors++;
            $display("FAIL x0_read: got rd=%h busy=%b pend=%b want 0/0/0",
                     rd_a[31:0], rd_busy_a[0], pending_a);
        end
        checks++;
        if (rd_b[31:0] !== 32'h0 || rd_busy_b[0] !== 1'b0 || pending_b !== 1'b0) begin
            errors++;
            $display("FAIL x30_oob_read: got rd=%h busy=%b pend=%b want 0/0/0",
                     rd_b[31:0], rd_busy_b[0], pending_b);
        end
        we_b = 1'b1; wa_b = 5'd23; wd_b = 32'h0000_0023; step();
        idle_inputs();
        ra_b = {5'd0, 5'd0, 5'd23, 5'd0};
        #1;
        checks++;
        if (rd_b[63:32] !== 32'h0000_0023) begin
            errors++; $display("FAIL x23_top_reg: got %h want 00000023", rd_b[63:32]);
        end
    endtask

    task automatic test_bypass();
        ra_a = {5'd5, 5'd7};
        we_a = 1'b1; wa_a = 5'd7; wd_a = 32'h1234_5678;
        #1;
        checks++;
        if (rd_a[31:0] !== 32'h1234_5678 || rd_busy_a[0] !== 1'b0) begin
            errors++;
            $display("FAIL bypass: got rd=%h busy=%b want 12345678/0", rd_a[31:0], rd_busy_a[0]);
        end
        checks++;
        if (rd_a[63:32] !== 32'hADAD_0000) begin
            errors++; $display("FAIL bypass_other_port: got %h want adad0000", rd_a[63:32]);
        end
        step();
        idle_inputs();
        #1;
        checks++;
        if (rd_a[31:0] !== 32'h1234_5678) begin
            errors++; $display("FAIL bypass_stored: got %h want 12345678", rd_a[31:0]);
        end
    endtask

    task automatic test_scoreboard();
        ra_a = {5'd9, 5'd3};
        rsv_en_a = 1'b1; rsv_a_a = 5'd3;
        #1;
        checks++;
        if (rd_busy_a[0] !== 1'b0 || pending_a !== 1'b0) begin
            errors++;
            $display("FAIL rsv_not_early: got busy=%b pend=%b want 0/0", rd_busy_a[0], pending_a);
        end
        step();
        idle_inputs();
        #1;
        checks++;
        if (rd_busy_a !== 2'b01 || pending_a !== 1'b1) begin
            errors++; $display("FAIL rsv_visible: got busy=%b pend=%b want 01/1", rd_busy_a, pending_a);
        end
        we_a = 1'b1; wa_a = 5'd3; wd_a = 32'h0000_CAFE;
        #1;
        checks++;
        if (rd_busy_a[0] !== 1'b0 || rd_a[31:0] !== 32'h0000_CAFE || pending_a !== 1'b1) begin
            errors++;
            $display("FAIL wb_bypass_clear: got rd=%h busy=%b pend=%b want 0000cafe/0/1",
                     rd_a[31:0], rd_busy_a[0], pending_a);
        end
        step();
        idle_inputs();
        #1;
        checks++;
        if (rd_busy_a[0] !== 1'b0 || rd_a[31:0] !== 32'h0000_CAFE || pending_a !== 1'b0) begin
            errors++;
            $display("FAIL wb_clear_state: got rd=%h busy=%b pend=%b want 0000cafe/0/0",
                     rd_a[31:0], rd_busy_a[0], pending_a);
        end
        we_a = 1'b1; wa_a = 5'd3; wd_a = 32'h0000_BEEF;
        rsv_en_a = 1'b1; rsv_a_a = 5'd3;
        step();
        idle_inputs();
        #1;
        checks++;
        if (rd_busy_a[0] !== 1'b1 || rd_a[31:0] !== 32'h0000_BEEF || pending_a !== 1'b1) begin
            errors++;
            $display("FAIL wr_rsv_same_edge: got rd=%h busy=%b pend=%b want 0000beef/1/1",
                     rd_a[31:0], rd_busy_a[0], pending_a);
        end
    endtask

    task automatic test_flush();
        rsv_en_a = 1'b1; rsv_a_a = 5'd2; step();
        rsv_a_a = 5'd4; step();
        idle_inputs();
        ra_a = {5'd4, 5'd2};
        #1;
        checks++;
        if (rd_busy_a !== 2'b11 || pending_a !== 1'b1) begin
            errors++; $display("FAIL pre_flush: got busy=%b pend=%b want 11/1", rd_busy_a, pending_a);
        end
        flush_a = 1'b1;
        rsv_en_a = 1'b1; rsv_a_a = 5'd6;
        we_a = 1'b1; wa_a = 5'd2; wd_a = 32'h0000_0055;
        step();
        idle_inputs();
        ra_a = {5'd2, 5'd6};
        #1;
        checks++;
        if (rd_busy_a !== 2'b00 || pending_a !== 1'b0) begin
            errors++; $display("FAIL flush_clear: got busy=%b pend=%b want 00/0", rd_busy_a, pending_a);
        end
        checks++;
        if (rd_a[63:32] !== 32'h0000_0055) begin
            errors++; $display("FAIL flush_write_kept: got %h want 00000055", rd_a[63:32]);
        end
        ra_a = {5'd3, 5'd4};
        #1;
        checks++;
        if (rd_busy_a !== 2'b00) begin
            errors++; $display("FAIL flush_x3_x4: got busy=%b want 00", rd_busy_a);
        end

        rsv_en_b = 1'b1; rsv_a_b = 5'd2; step();
        idle_inputs();
        ra_b = {5'd2, 5'd2, 5'd2, 5'd2};
        #1;
        checks++;
        if (rd_busy_b !== 4'b1111 || pending_b !== 1'b1) begin
            errors++; $display("FAIL b_pre_flush: got busy=%b pend=%b want 1111/1", rd_busy_b, pending_b);
        end
        flush_b = 1'b1;
        rsv_en_b = 1'b1; rsv_a_b = 5'd6;
        we_b = 1'b1; wa_b = 5'd2; wd_b = 32'h0000_0055;
        step();
        idle_inputs();
        #1;
        checks++;
        if (rd_b !== {4{32'h0000_0055}} || rd_busy_b !== 4'b0000 || pending_b !== 1'b0) begin
            errors++;
            $display("FAIL b_flush_4port: got rd=%h busy=%b pend=%b want 4x00000055/0000/0",
                     rd_b, rd_busy_b, pending_b);
        end
        ra_b = {5'd0, 5'd0, 5'd0, 5'd6};
        #1;
        checks++;
        if (rd_busy_b[0] !== 1'b0) begin
            errors++; $display("FAIL b_flush_x6: got busy=%b want 0", rd_busy_b[0]);
        end
    endtask

    task automatic test_reset_midrun();
        rsv_en_a = 1'b1; rsv_a_a = 5'd8; step();
        idle_inputs();
        ra_a = {5'd1, 5'd5};
        ra_b = {5'd0, 5'd0, 5'd23, 5'd2};
        #1;
        checks++;
        if (rd_a !== {32'h0000_0001, 32'hADAD_0000} || pending_a !== 1'b1) begin
            errors++; $display("FAIL pre_reset: got rd=%h pend=%b want 00000001adad0000/1", rd_a, pending_a);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (rd_a !== 64'h0 || rd_busy_a !== 2'b00 || pending_a !== 1'b0) begin
            errors++;
            $display("FAIL async_reset_a: got rd=%h busy=%b pend=%b want 0/00/0", rd_a, rd_busy_a, pending_a);
        end
        checks++;
        if (rd_b[63:0] !== 64'h0 || pending_b !== 1'b0) begin
            errors++; $display("FAIL async_reset_b: got rd=%h pend=%b want 0/0", rd_b[63:0], pending_b);
        end
        we_a = 1'b1; wa_a = 5'd5; wd_a = 32'hDEAD_BEEF;
        rsv_en_a = 1'b1; rsv_a_a = 5'd1;
        step();
        idle_inputs();
        rst = 1'b1;
        #1;
        checks++;
        if (rd_a !== 64'h0 || rd_busy_a !== 2'b00 || pending_a !== 1'b0) begin
            errors++;
            $display("FAIL held_in_reset: got rd=%h busy=%b pend=%b want 0/00/0", rd_a, rd_busy_a, pending_a);
        end
    endtask

    initial begin
        test_reset();
        test_write_readback();
        test_x0_range();
        test_bypass();
        test_scoreboard();
        test_flush();
        test_reset_midrun();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
